// File: rtl/spart_key_decoder.sv
// rtl/spart_key_decoder.sv - ASCII keystroke to held-key bitmap decoder with rate-limited SPART write pulses
module spart_key_decoder #(
    parameter int CNT_W       = 24,
    parameter int HOLD_CYCLES = 2500000,
    parameter int GAP_W       = 16,
    parameter int MIN_GAP     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        SPART_we,
    output logic [12:0] SPART_keys,
    output logic [12:0] key_state,
    output logic [7:0]  unknown_cnt
);

    localparam int NKEYS = 13;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(MIN_GAP);

    logic [7:0]       folded;
    logic [NKEYS-1:0] key_hit;
    logic             esc_hit;
    logic             unk_hit;

    logic [NKEYS-1:0] key_state_q, key_state_d;
    logic [CNT_W-1:0] hold_q [NKEYS];
    logic [CNT_W-1:0] hold_d [NKEYS];
    logic [7:0]       unknown_q, unknown_d;

    // SPART_keys doubles as the last-sent bitmap: both only change on a pulse edge
    logic [NKEYS-1:0] sent_q, sent_d;
    logic             we_q, we_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    always_comb begin
        folded = rx_data;
        if (rx_data >= 8'h41 && rx_data <= 8'h5A) begin
            folded = rx_data | 8'h20;
        end
        key_hit = '0;
        esc_hit = 1'b0;
        unk_hit = 1'b0;
        if (rx_valid) begin
            case (folded)
                8'h77:   key_hit[0]  = 1'b1;
                8'h73:   key_hit[1]  = 1'b1;
                8'h61:   key_hit[2]  = 1'b1;
                8'h64:   key_hit[3]  = 1'b1;
                8'h72:   key_hit[4]  = 1'b1;
                8'h66:   key_hit[5]  = 1'b1;
                8'h69:   key_hit[6]  = 1'b1;
                8'h6B:   key_hit[7]  = 1'b1;
                8'h6A:   key_hit[8]  = 1'b1;
                8'h6C:   key_hit[9]  = 1'b1;
                8'h75:   key_hit[10] = 1'b1;
                8'h6F:   key_hit[11] = 1'b1;
                8'h20:   key_hit[12] = 1'b1;
                8'h1B:   esc_hit     = 1'b1;
                default: unk_hit     = 1'b1;
            endcase
        end
    end

    // A press on the expiry edge takes priority over the 1->0 release
    always_comb begin
        key_state_d = key_state_q;
        for (int b = 0; b < NKEYS; b++) begin
            hold_d[b] = hold_q[b];
            if (esc_hit) begin
                hold_d[b]      = '0;
                key_state_d[b] = 1'b0;
            end else if (key_hit[b]) begin
                hold_d[b]      = HOLD_LOAD;
                key_state_d[b] = 1'b1;
            end else if (hold_q[b] != '0) begin
                hold_d[b] = hold_q[b] - CNT_W'(1);
                if (hold_q[b] == CNT_W'(1)) begin
                    key_state_d[b] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        unknown_d = unknown_q;
        if (unk_hit && unknown_q != 8'hFF) begin
            unknown_d = unknown_q + 8'd1;
        end
    end

    // Emitter: READY when gap_q is zero, otherwise counting down the gap
    always_comb begin
        we_d   = 1'b0;
        sent_d = sent_q;
        gap_d  = gap_q;
        if (gap_q == '0) begin
            if (key_state_q != sent_q) begin
                we_d   = 1'b1;
                sent_d = key_state_q;
                gap_d  = GAP_LOAD;
            end
        end else begin
            gap_d = gap_q - GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_state_q <= '0;
            unknown_q   <= '0;
            sent_q      <= '0;
            we_q        <= 1'b0;
            gap_q       <= '0;
            for (int b = 0; b < NKEYS; b++) begin
                hold_q[b] <= '0;
            end
        end else begin
            key_state_q <= key_state_d;
            unknown_q   <= unknown_d;
            sent_q      <= sent_d;
            we_q        <= we_d;
            gap_q       <= gap_d;
            for (int b = 0; b < NKEYS; b++) begin
                hold_q[b] <= hold_d[b];
            end
        end
    end

    assign SPART_we    = we_q;
    assign SPART_keys  = sent_q;
    assign key_state   = key_state_q;
    assign unknown_cnt = unknown_q;

endmodule

// File: tb/tb_spart_key_decoder.sv
// tb/tb_spart_key_decoder.sv - directed self-checking bench for spart_key_decoder
module tb_spart_key_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        SPART_we;
    logic [12:0] SPART_keys;
    logic [12:0] key_state;
    logic [7:0]  unknown_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int last_e;
    int prev_pulse_e = -1000;
    int min_spacing  = 1000;
    int consec_hi    = 0;
    logic prev_we    = 1'b0;

    int          pe[$];
    logic [12:0] pk[$];

    spart_key_decoder #(
        .CNT_W(24), .HOLD_CYCLES(20), .GAP_W(16), .MIN_GAP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .SPART_we(SPART_we), .SPART_keys(SPART_keys),
        .key_state(key_state), .unknown_cnt(unknown_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (SPART_we === 1'b1) begin
            pe.push_back(edge_cnt);
            pk.push_back(SPART_keys);
            if (edge_cnt - prev_pulse_e < min_spacing) min_spacing = edge_cnt - prev_pulse_e;
            prev_pulse_e = edge_cnt;
            if (prev_we === 1'b1) consec_hi++;
        end
        prev_we = SPART_we;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic clear_q();
        pe.delete();
        pk.delete();
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(3);
        rst_n = 1'b1;

        // 1: idle after reset
        tick(50);
        check("idle_pulses", pe.size(), 0);
        check("idle_keys", SPART_keys, 0);
        check("idle_state", key_state, 0);
        check("idle_unknown", unknown_cnt, 0);

        // 2: single 'w' press and release
        clear_q();
        send(8'h77);
        check("w_state", key_state, 13'h0001);
        check("w_no_we_yet", SPART_we, 0);
        tick(1);
        check("w_we", SPART_we, 1);
        check("w_keys", SPART_keys, 13'h0001);
        tick(1);
        check("w_we_low", SPART_we, 0);
        tick(17);
        check("w_held_n19", key_state, 13'h0001);
        tick(1);
        check("w_released_n20", key_state, 13'h0000);
        tick(1);
        check("w_rel_we", SPART_we, 1);
        check("w_rel_keys", SPART_keys, 13'h0000);
        tick(10);
        check("w_pulse_cnt", pe.size(), 2);
        if (pe.size() == 2) check("w_rel_spacing", pe[1] - pe[0], 20);

        // 3: 'W' folds to 'w', then space two cycles later
        clear_q();
        send(8'h57);
        send(8'h20);
        check("ws_state", key_state, 13'h1001);
        tick(40);
        check("ws_pulse_cnt", pe.size(), 4);
        if (pe.size() == 4) begin
            check("ws_p0", pk[0], 13'h0001);
            check("ws_p1", pk[1], 13'h1001);
            check("ws_spacing", pe[1] - pe[0], 5);
            check("ws_p2", pk[2], 13'h1000);
            check("ws_p3", pk[3], 13'h0000);
        end

        // 4: auto-repeat 'd' every 15 cycles keeps it held
        clear_q();
        for (int k = 0; k < 7; k++) begin
            send(8'h64);
            last_e = edge_cnt;
            check("d_held_press", key_state, 13'h0008);
            tick(13);
            check("d_held_gap", key_state, 13'h0008);
        end
        tick(20);
        check("d_pulse_cnt", pe.size(), 2);
        if (pe.size() == 2) begin
            check("d_rise_keys", pk[0], 13'h0008);
            check("d_rel_keys", pk[1], 13'h0000);
            check("d_rel_latency", pe[1] - last_e, 21);
        end

        // 4b: re-press exactly on the expiry edge
        clear_q();
        send(8'h64);
        tick(18);
        check("coll_before", key_state, 13'h0008);
        send(8'h64);
        check("coll_press_wins", key_state, 13'h0008);
        tick(3);
        check("coll_one_pulse", pe.size(), 1);
        tick(30);
        check("coll_two_pulses", pe.size(), 2);
        check("coll_final_state", key_state, 0);

        // 5: ESC clears held keys
        clear_q();
        send(8'h61);
        send(8'h73);
        tick(3);
        check("as_state", key_state, 13'h0006);
        send(8'h1B);
        check("esc_state", key_state, 13'h0000);
        tick(30);
        check("esc_pulse_cnt", pe.size(), 3);
        if (pe.size() == 3) begin
            check("esc_p0", pk[0], 13'h0004);
            check("esc_p1", pk[1], 13'h0006);
            check("esc_p2", pk[2], 13'h0000);
        end
        check("esc_unknown", unknown_cnt, 0);

        // 6: unknown bytes and saturation
        clear_q();
        send(8'h7A);
        send(8'h31);
        check("unk_two", unknown_cnt, 2);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        tick(100);
        check("unk_102", unknown_cnt, 102);
        tick(200);
        rx_valid = 1'b0;
        check("unk_sat", unknown_cnt, 8'hFF);
        tick(5);
        check("unk_no_pulse", pe.size(), 0);
        check("unk_state", key_state, 0);

        // 6b: reset mid-hold drops the pending pulse
        clear_q();
        send(8'h69);
        tick(2);
        check("rst_pre_keys", SPART_keys, 13'h0040);
        send(8'h6B);
        check("rst_pre_state", key_state, 13'h00C0);
        rst_n = 1'b0;
        tick(1);
        check("rst_we", SPART_we, 0);
        check("rst_keys", SPART_keys, 0);
        check("rst_state", key_state, 0);
        check("rst_unknown", unknown_cnt, 0);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        check("rst_no_pulse", pe.size(), 1);
        check("rst_state_after", key_state, 0);

        check("never_consec_we", consec_hi, 0);
        check("min_spacing_ok", (min_spacing >= 5) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
